// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter:
//   owner_e  - tag recording which requester owns the read response in flight
//   state_e  - arbiter FSM states (free arbitration / data port locked)
//   MAX_WAIT_DEFAULT - default starvation limit for the fetch port
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_DLOCK = 1'b1
    } state_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 4;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_starve_counter
// 4-bit saturating counter of consecutive denied fetch cycles.
// Priority: hold > clear > increment.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   inc_i       - count one more denied cycle (saturates at MAX_VAL)
//   clr_i       - return to zero
//   hold_i      - freeze the current value
//   cnt_o       - current count
// -----------------------------------------------------------------------------
module mem_port_arbiter_starve_counter #(
    parameter int unsigned MAX_VAL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       clr_i,
    input  logic       hold_i,
    output logic [3:0] cnt_o
);

    localparam logic [3:0] MAX_C = 4'(MAX_VAL);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // NOTE: default assignment first so every path drives cnt_d -> no latch.
    always_comb begin
        cnt_d = cnt_q;
        if (hold_i) begin
            cnt_d = cnt_q;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < MAX_C)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : mem_port_arbiter_starve_counter

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous SRAM between the instruction-fetch port
// and the load/store port. Data has fixed priority over fetch, except when
// fetch has been denied MAX_WAIT consecutive cycles. A locked data access
// keeps the memory owned by the data port until an unlocking data access.
// Read data is returned to the owning port one cycle after its grant.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   if_req_i/if_addr_i             - fetch request and byte address
//   if_gnt_o                       - fetch accepted this cycle
//   if_rvalid_o/if_rdata_o         - fetch response (one-cycle pulse)
//   d_req_i/d_we_i/d_lock_i        - data request, store flag, lock flag
//   d_addr_i/d_wdata_i/d_be_i      - data byte address, store data, byte enables
//   d_gnt_o                        - data access accepted this cycle
//   d_rvalid_o/d_rdata_o           - load response (one-cycle pulse)
//   mem_en_o/mem_we_o/mem_be_o     - SRAM enable, write enable, byte enables
//   mem_addr_o/mem_wdata_o         - SRAM word address, write data
//   mem_rdata_i                    - SRAM read data (cycle after read enable)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic                  d_lock_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    input  logic [DATA_W/8-1:0]   d_be_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-3:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic [3:0] starve_cnt;
    logic       fetch_starved;
    logic       if_gnt, d_gnt;

    // Byte-offset bits are not used for word addressing.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr_i[1:0], d_addr_i[1:0]};

    assign fetch_starved = (starve_cnt == MAX_WAIT_C);

    // ---------------------------------------------------------------- grants
    // Grants are also gated by rst_n so every output reads 0 while reset is
    // held, even with requests present.
    always_comb begin
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        state_d = state_q;
        if (rst_n) begin
            if (state_q == ST_DLOCK) begin
                d_gnt = d_req_i;
            end else if (d_req_i && !(fetch_starved && if_req_i)) begin
                d_gnt = 1'b1;
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end
        end
        // Every data grant decides whether the data port keeps ownership.
        if (d_gnt) begin
            state_d = d_lock_i ? ST_DLOCK : ST_ARB;
        end
    end

    assign if_gnt_o = if_gnt;
    assign d_gnt_o  = d_gnt;

    // ---------------------------------------------------------- starvation
    mem_port_arbiter_starve_counter #(
        .MAX_VAL (MAX_WAIT)
    ) u_starve_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (if_req_i && !if_gnt),
        .clr_i  (if_gnt || !if_req_i),
        .hold_i (state_q == ST_DLOCK),
        .cnt_o  (starve_cnt)
    );

    // ------------------------------------------------------------- mem mux
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (d_gnt) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_be_o    = d_we_i ? d_be_i : '1;
            mem_addr_o  = d_addr_i[ADDR_W-1:2];
            mem_wdata_o = d_wdata_i;
        end else if (if_gnt) begin
            mem_en_o    = 1'b1;
            mem_be_o    = '1;
            mem_addr_o  = if_addr_i[ADDR_W-1:2];
        end
    end

    // ------------------------------------------------------------ response
    // Stores complete at grant, so only reads claim the response slot.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt && !d_we_i) begin
            owner_d = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign if_rvalid_o = (owner_q == OWN_IF);
    assign d_rvalid_o  = (owner_q == OWN_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;

endmodule : mem_port_arbiter

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous SRAM between the core's instruction-fetch port and its load/store port, replacing separate instruction and data memories with a unified memory. The block uses valid/grant handshakes on each requester side, fixed data-over-fetch priority with a starvation guard, and a lock mode for read-modify-write sequences. It routes read data back to the owning requester one cycle after grant.

## Interface
- ADDR_W, 32, byte address width of both requesters
- DATA_W, 32, data width; byte enables are DATA_W/8 wide
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win; legal range 1–15
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid; one-cycle pulse
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_lock  in  1  keep the memory owned by the data port after this access
- d_addr  in  ADDR_W  data byte address; bits [1:0] ignored
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data valid; one-cycle pulse
- d_rdata  out  DATA_W  load read data
- mem_en, mem_we  out  1  SRAM enable and write enable
- mem_be  out  DATA_W/8  SRAM byte enables
- mem_addr  out  ADDR_W-2  SRAM word address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

## Operation
- At most one grant per cycle. Grant and mem_* outputs are combinational from requests and registered state.
- Winner selection:
  - State ARB:
    - Data wins when d_req=1, unless starve_cnt equals MAX_WAIT.
    - When starve_cnt equals MAX_WAIT and if_req=1, fetch wins.
    - Otherwise fetch wins if if_req=1.
  - State DLOCK: only data can be granted; if_gnt=0.
- starve_cnt (4 bit):
  - Increments when if_req=1 and if_gnt=0, saturating at MAX_WAIT.
  - Clears when if_gnt=1 or if_req=0.
  - Holds its value in DLOCK.
- FSM:
  - ARB→DLOCK on d_gnt with d_lock=1.
  - DLOCK→ARB on d_gnt with d_lock=0.
  - DLOCK with no d_req stays in DLOCK.
- mem_* on grant:
  - mem_en=1 and mem_addr=addr[ADDR_W-1:2].
  - Fetch: mem_we=0, mem_be=all ones.
  - Data: mem_we=d_we, mem_be=d_be when d_we=1, else all ones; mem_wdata=d_wdata.
  - With no grant: mem_en=0, mem_we=0, all other mem_* outputs 0.
- Response:
  - A registered owner tag {none, IF, D} is set on each granted read.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata. The other rdata output is 0.
  - Stores produce no rvalid; a store completes at d_gnt.

## Timing
- Reset values:
  - if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we = 0.
  - All data, address and byte-enable outputs = 0.
  - State ARB, starve_cnt=0, owner none.
- Read latency: grant in cycle N, rvalid in cycle N+1.
- Back-to-back grants are allowed every cycle. A response for grant N and grant N+1 can overlap across the two ports.
- Simultaneous if_req and d_req with starve_cnt < MAX_WAIT: d_gnt=1. Fetch then wins at the latest on the (MAX_WAIT+1)-th consecutive contended cycle.
- Reset asserted mid-operation: pending rvalid is dropped, state returns to ARB, counter clears. No response is emitted after rst_n deasserts.
- Requester drops req before gnt: illegal. The arbiter still behaves from current inputs only.

## Structure
- Shared package holds:
  - The owner tag encoding (OWN_NONE, OWN_IF, OWN_D).
  - The FSM state encoding (ST_ARB, ST_DLOCK).
  - The default MAX_WAIT constant.
- Natural sub-module: starve_counter, a saturating counter with clear and hold inputs.
- The rest is flat: the FSM, grant logic, mem mux and response register.

## Test plan
- Fetch only: if_req=1, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle → mem_addr=0x4, if_gnt=1; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Contention, MAX_WAIT=4: if_req and d_req held high with data requests back-to-back → d_gnt for 4 cycles, if_gnt in the 5th cycle, starve_cnt back to 0.
- Store with d_be=4'b0011, d_addr=0x24, d_wdata=0x1234_5678 → mem_we=1, mem_be=4'b0011, mem_addr=0x9; no d_rvalid.
- Lock: load with d_lock=1, then if_req=1 for 6 cycles, then store with d_lock=0 → if_gnt=0 throughout the lock; if_gnt=1 in the cycle after the unlocking store.
- Back-to-back: data read granted in cycle N, fetch read granted in cycle N+1 → d_rvalid in N+1, if_rvalid in N+2, each with the matching mem_rdata.
- Reset mid-flight: rst_n low in the cycle after a read grant → no rvalid; all outputs 0 during reset; first grant after release behaves as in the fetch-only case.
